// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86-64 encodings and controller state type for pipe_ctrl.
// Holds the icode/register/status constants the hazard logic compares against.
package pipe_ctrl_pkg;

    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;

    typedef enum logic [1:0] {
        CTRL_RUN  = 2'b00,
        CTRL_RET  = 2'b01,
        CTRL_HALT = 2'b10
    } ctrl_state_e;

    // Any status other than AOK (including a bubble status) counts as an exception.
    function automatic logic stat_exc(input logic [2:0] stat);
        return (stat != SAOK);
    endfunction

    function automatic logic load_use_hazard(
        input logic [3:0] e_icode,
        input logic [3:0] e_dstm,
        input logic [3:0] src_a,
        input logic [3:0] src_b
    );
        return ((e_icode == IMRMOVQ) || (e_icode == IPOPQ)) &&
               (e_dstm != RNONE) &&
               ((e_dstm == src_a) || (e_dstm == src_b));
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter: +1 per cycle inc_i is high, holds while freeze_i is high.
module pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         freeze_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: stops at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (freeze_i) begin
            cnt_d = cnt_q;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline hazard controller: stall/bubble generation, ret drain and halt latch.
// Optional stall/bubble performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RET_DRAIN_CYC = 3
`ifdef PIPE_PERF_CNT_EN
   ,parameter int CNT_W = 32
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] D_icode_i,
    input  logic [3:0] d_srcA_i,
    input  logic [3:0] d_srcB_i,
    input  logic [3:0] E_icode_i,
    input  logic [3:0] E_dstM_i,
    input  logic       e_cnd_i,
    input  logic [2:0] m_stat_i,
    input  logic [2:0] W_stat_i,
    output logic       F_stall_o,
    output logic       D_stall_o,
    output logic       D_bubble_o,
    output logic       E_bubble_o,
    output logic       M_bubble_o,
    output logic       W_stall_o,
    output logic       set_cc_o,
    output logic       halted_o
`ifdef PIPE_PERF_CNT_EN
   ,output logic [CNT_W-1:0] perf_stall_o,
    output logic [CNT_W-1:0] perf_bubble_o
`endif
);

    localparam int DW = (RET_DRAIN_CYC > 2) ? $clog2(RET_DRAIN_CYC) : 1;

    ctrl_state_e   state_d;
    ctrl_state_e   state_q;
    logic [DW-1:0] cnt_d;
    logic [DW-1:0] cnt_q;
    logic          halted_q;
    logic          load_use_s;
    logic          mispred_s;
    logic          m_exc_s;
    logic          w_exc_s;
    logic          ret_go_s;

    // Raw hazard conditions; a ret only launches from RUN when nothing older blocks it.
    always_comb begin
        load_use_s = load_use_hazard(E_icode_i, E_dstM_i, d_srcA_i, d_srcB_i);
        mispred_s  = (E_icode_i == IJXX) && !e_cnd_i;
        m_exc_s    = stat_exc(m_stat_i);
        w_exc_s    = stat_exc(W_stat_i);
        ret_go_s   = (state_q == CTRL_RUN) && (D_icode_i == IRET) && !load_use_s && !mispred_s;
    end

    // Zero-latency stage controls; forced low while reset is asserted.
    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        W_stall_o  = 1'b0;
        set_cc_o   = 1'b0;
        if (rst_i) begin
            F_stall_o = 1'b0;
        end else begin
            case (state_q)
                CTRL_RUN: begin
                    F_stall_o  = load_use_s | ret_go_s;
                    D_stall_o  = load_use_s;
                    D_bubble_o = mispred_s | ret_go_s;
                    E_bubble_o = mispred_s | load_use_s;
                    M_bubble_o = m_exc_s | w_exc_s;
                    W_stall_o  = w_exc_s;
                    set_cc_o   = (E_icode_i == IOPQ) && !m_exc_s && !w_exc_s;
                end
                CTRL_RET: begin
                    F_stall_o  = 1'b1;
                    D_bubble_o = 1'b1;
                    M_bubble_o = m_exc_s | w_exc_s;
                    W_stall_o  = w_exc_s;
                    set_cc_o   = (E_icode_i == IOPQ) && !m_exc_s && !w_exc_s;
                end
                CTRL_HALT: begin
                    F_stall_o  = 1'b1;
                    D_stall_o  = 1'b1;
                    M_bubble_o = 1'b1;
                    W_stall_o  = 1'b1;
                end
                default: begin
                    F_stall_o = 1'b0;
                end
            endcase
        end
    end

    // Next state: a W exception wins over both ret launch and drain exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CTRL_RUN: begin
                if (w_exc_s) begin
                    state_d = CTRL_HALT;
                    cnt_d   = {DW{1'b0}};
                end else if (ret_go_s) begin
                    state_d = CTRL_RET;
                    cnt_d   = DW'(RET_DRAIN_CYC - 1);
                end else begin
                    state_d = CTRL_RUN;
                end
            end
            CTRL_RET: begin
                if (w_exc_s) begin
                    state_d = CTRL_HALT;
                    cnt_d   = {DW{1'b0}};
                end else if (cnt_q == DW'(1)) begin
                    state_d = CTRL_RUN;
                    cnt_d   = {DW{1'b0}};
                end else begin
                    cnt_d   = cnt_q - DW'(1);
                end
            end
            CTRL_HALT: begin
                state_d = CTRL_HALT;
            end
            default: begin
                state_d = CTRL_RUN;
                cnt_d   = {DW{1'b0}};
            end
        endcase
    end

    // State, drain counter and registered halt flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= CTRL_RUN;
            cnt_q    <= {DW{1'b0}};
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == CTRL_HALT);
        end
    end

    assign halted_o = halted_q;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (F_stall_o),
        .freeze_i (state_q == CTRL_HALT),
        .cnt_o    (perf_stall_o)
    );

    pipe_perf_cnt #(.W(CNT_W)) u_bubble_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (D_bubble_o | E_bubble_o),
        .freeze_i (state_q == CTRL_HALT),
        .cnt_o    (perf_bubble_o)
    );
`endif

endmodule
